risc_run_ctrl: RTL and testbench

RISC_RUN_CTRL -- requirements
Module: risc_run_ctrl

---
 rtl/risc_defs_pkg.sv | 24 ++
 rtl/risc_cycle_counter.sv | 34 +++
 rtl/risc_run_ctrl.sv | 125 ++++++++++++
 tb/tb_risc_run_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/risc_defs_pkg.sv
// Shared definitions for the risc core run controller: state encoding and
// default sequencing constants.
package risc_defs;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HOLD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DONE = 3'd3,
    ST_TOUT = 3'd4
  } run_state_e;

  localparam int unsigned DEF_HOLD_CYCLES = 4;
  localparam int unsigned DEF_TIMEOUT     = 1024;
  localparam int unsigned DEF_CNT_W       = 32;
  localparam int unsigned HOLD_CNT_W      = 8;

  // The core is out of reset while running and after a clean end of program,
  // so its architectural state can be inspected once halted.
  function automatic logic core_released(run_state_e s);
    return (s == ST_RUN) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/risc_cycle_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable and
// the count sticks at all-ones instead of wrapping.
module risc_cycle_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         enable_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/risc_run_ctrl.sv
// Run controller for the risc core: holds the core in reset, releases it for
// a program run and ends the run on end-of-program, watchdog expiry or abort.
module risc_run_ctrl
  import risc_defs::*;
#(
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             eop,
  output logic             core_rst_n,
  output logic             run,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]      WDOG_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit                    WDOG_EN   = (TIMEOUT != 0);

  run_state_e            state_q, state_d;
  logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic                  core_rst_n_q, core_rst_n_d;
  logic                  run_q, run_d;
  logic                  done_q, done_d;
  logic                  tout_q, tout_d;
  logic                  launch;
  logic                  wdog_hit;

  assign launch   = start && !abort &&
                    ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_TOUT));
  assign wdog_hit = WDOG_EN && (cycle_count == WDOG_LAST);

  // The edge that leaves RUN, including an abort, still counts as a RUN cycle.
  risc_cycle_counter #(
    .W (CNT_W)
  ) u_cycle_counter (
    .clk_i    (clk),
    .rst_ni   (reset),
    .clear_i  (launch),
    .enable_i (state_q == ST_RUN),
    .count_o  (cycle_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      hold_cnt_q   <= '0;
      core_rst_n_q <= 1'b0;
      run_q        <= 1'b0;
      done_q       <= 1'b0;
      tout_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      core_rst_n_q <= core_rst_n_d;
      run_q        <= run_d;
      done_q       <= done_d;
      tout_q       <= tout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE, ST_TOUT: begin
          if (start) begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
          end
        end
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d = ST_RUN;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (eop) begin
            state_d = ST_DONE;
          end else if (wdog_hit) begin
            state_d = ST_TOUT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they appear registered in the
  // same cycle as the state they describe.
  always_comb begin
    core_rst_n_d = core_released(state_d);
    run_d        = (state_d == ST_RUN);
    done_d       = done_q;
    tout_d       = tout_q;
    if (launch) begin
      done_d = 1'b0;
      tout_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      if (state_d == ST_DONE) begin
        done_d = 1'b1;
      end
      if (state_d == ST_TOUT) begin
        tout_d = 1'b1;
      end
    end
  end

  assign core_rst_n = core_rst_n_q;
  assign run        = run_q;
  assign done       = done_q;
  assign timeout    = tout_q;

endmodule

// File: tb/tb_risc_run_ctrl.sv
// Directed bench for risc_run_ctrl: a TIMEOUT=16 instance for sequencing,
// watchdog, abort and reset, plus a narrow watchdog-off instance for saturation.
module tb_risc_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort, eop;
  logic        coreRstN, run, done, timeout;
  logic [31:0] cycleCount;

  logic        start2, abort2, eop2;
  logic        coreRstN2, run2, done2, timeout2;
  logic [3:0]  cycleCount2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  risc_run_ctrl #(
    .HOLD_CYCLES (4),
    .TIMEOUT     (16),
    .CNT_W       (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .eop         (eop),
    .core_rst_n  (coreRstN),
    .run         (run),
    .done        (done),
    .timeout     (timeout),
    .cycle_count (cycleCount)
  );

  risc_run_ctrl #(
    .HOLD_CYCLES (1),
    .TIMEOUT     (0),
    .CNT_W       (4)
  ) dutSat (
    .clk         (clk),
    .reset       (reset),
    .start       (start2),
    .abort       (abort2),
    .eop         (eop2),
    .core_rst_n  (coreRstN2),
    .run         (run2),
    .done        (done2),
    .timeout     (timeout2),
    .cycle_count (cycleCount2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic e);
    start = s;
    abort = a;
    eop   = e;
  endtask

  // Start pulse, four HOLD cycles with the core in reset, then first RUN cycle.
  task automatic launchRun(input string tag, input bit pokeStart);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput({tag, "_hold_rst"}, coreRstN, 0);
    checkOutput({tag, "_hold_cnt"}, cycleCount, 0);
    checkOutput({tag, "_hold_done"}, done, 0);
    checkOutput({tag, "_hold_tout"}, timeout, 0);
    for (int i = 1; i <= 3; i++) begin
      if (pokeStart && i == 2) start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput({tag, "_hold_rst_n"}, coreRstN, 0);
      checkOutput({tag, "_hold_run"}, run, 0);
    end
    tick();
    checkOutput({tag, "_run_up"}, run, 1);
    checkOutput({tag, "_run_rst_n"}, coreRstN, 1);
    checkOutput({tag, "_run_cnt0"}, cycleCount, 0);
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    start2 = 1'b0;
    abort2 = 1'b0;
    eop2   = 1'b0;

    tick();
    tick();
    checkOutput("rst_core", coreRstN, 0);
    checkOutput("rst_run", run, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_tout", timeout, 0);
    checkOutput("rst_cnt", cycleCount, 0);
    reset = 1'b1;

    // Idle after reset release; eop outside RUN has no effect.
    eop = 1'b1;
    tick();
    tick();
    eop = 1'b0;
    checkOutput("idle_run", run, 0);
    checkOutput("idle_core", coreRstN, 0);
    checkOutput("idle_done", done, 0);

    // eop on the 10th RUN edge.
    launchRun("r1", 1'b0);
    for (int i = 0; i < 9; i++) tick();
    checkOutput("r1_cnt9", cycleCount, 9);
    checkOutput("r1_run9", run, 1);
    eop = 1'b1;
    tick();
    checkOutput("r1_done", done, 1);
    checkOutput("r1_run", run, 0);
    checkOutput("r1_cnt", cycleCount, 10);
    checkOutput("r1_core", coreRstN, 1);
    checkOutput("r1_tout", timeout, 0);
    tick();
    tick();
    eop = 1'b0;
    checkOutput("r1_frozen", cycleCount, 10);
    checkOutput("r1_done_sticky", done, 1);

    // Watchdog expiry with eop held low.
    launchRun("r2", 1'b1);
    for (int i = 0; i < 15; i++) tick();
    checkOutput("r2_cnt15", cycleCount, 15);
    checkOutput("r2_tout15", timeout, 0);
    tick();
    checkOutput("r2_tout", timeout, 1);
    checkOutput("r2_cnt", cycleCount, 16);
    checkOutput("r2_core", coreRstN, 0);
    checkOutput("r2_done", done, 0);
    checkOutput("r2_run", run, 0);
    eop = 1'b1;
    tick();
    tick();
    eop = 1'b0;
    checkOutput("r2_frozen", cycleCount, 16);
    checkOutput("r2_done_ign", done, 0);

    // eop coinciding with watchdog expiry resolves to DONE.
    launchRun("r3", 1'b0);
    for (int i = 0; i < 15; i++) tick();
    eop = 1'b1;
    tick();
    eop = 1'b0;
    checkOutput("r3_done", done, 1);
    checkOutput("r3_tout", timeout, 0);
    checkOutput("r3_cnt", cycleCount, 16);
    checkOutput("r3_core", coreRstN, 1);

    // Abort with start on the 5th RUN edge, then restart.
    launchRun("r4", 1'b0);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("r4_cnt4", cycleCount, 4);
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("r4_abort_run", run, 0);
    checkOutput("r4_abort_core", coreRstN, 0);
    checkOutput("r4_abort_cnt", cycleCount, 5);
    tick();
    tick();
    checkOutput("r4_idle_run", run, 0);
    checkOutput("r4_idle_cnt", cycleCount, 5);
    launchRun("r5", 1'b0);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("r5_cnt3", cycleCount, 3);

    // Asynchronous reset between edges while running.
    #2;
    reset = 1'b0;
    #1;
    checkOutput("arst_core", coreRstN, 0);
    checkOutput("arst_run", run, 0);
    checkOutput("arst_cnt", cycleCount, 0);
    checkOutput("arst_done", done, 0);
    checkOutput("arst_tout", timeout, 0);
    reset = 1'b1;
    tick();
    tick();
    checkOutput("arst_stay_idle", run, 0);
    checkOutput("arst_stay_core", coreRstN, 0);

    // Narrow counter saturates at all-ones with the watchdog disabled.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    checkOutput("sat_run", run2, 1);
    checkOutput("sat_cnt0", cycleCount2, 0);
    for (int i = 0; i < 15; i++) tick();
    checkOutput("sat_cnt15", cycleCount2, 15);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("sat_hold", cycleCount2, 15);
    checkOutput("sat_no_tout", timeout2, 0);
    checkOutput("sat_still_run", run2, 1);
    eop2 = 1'b1;
    tick();
    eop2 = 1'b0;
    checkOutput("sat_done", done2, 1);
    checkOutput("sat_done_cnt", cycleCount2, 15);
    checkOutput("sat_core", coreRstN2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
